// File: rtl/stencil_fill_engine.sv
// Rectangle fill/clear initiator for the stencil cache: walks a pixel rectangle as
// 16-pixel blocks row by row, issuing one full-mode masked write per block.
module stencil_fill_engine (
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [8:0]  y0,
  input  logic [10:0] w,
  input  logic [9:0]  h,
  input  logic        fillBit,
  input  logic        writeGrant,
  output logic        busy,
  output logic        done,
  output logic        fullMode,
  output logic        stencilWriteSig,
  output logic [14:0] stencilWriteAdr,
  output logic [15:0] writeValue16,
  output logic [15:0] writeMask16
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e      state_q;
  logic [8:0]  line_q;
  logic [9:0]  lines_left_q;
  logic [6:0]  blk_cnt_q;
  logic [6:0]  blk_last_q;
  logic [5:0]  blk_first_q;
  logic [15:0] m_first_q;
  logic [15:0] m_last_q;
  logic [14:0] adr_q;
  logic [15:0] mask_q;
  logic [15:0] value_q;

  // Geometry decoded at start: last block index of a row and the edge masks.
  logic [11:0] span;
  logic [6:0]  start_last;
  logic [3:0]  xe_lo;
  logic [15:0] start_mfirst;
  logic [15:0] start_mlast;
  logic [15:0] start_mask;

  assign span         = {8'd0, x0[3:0]} + {1'b0, w} - 12'd1;
  assign start_last   = 7'(span >> 4);
  assign xe_lo        = x0[3:0] + w[3:0] - 4'd1;
  assign start_mfirst = 16'hFFFF << x0[3:0];
  assign start_mlast  = 16'hFFFF >> (4'd15 - xe_lo);
  assign start_mask   = (start_last == 7'd0) ? (start_mfirst & start_mlast) : start_mfirst;

  // Next block position after a granted write.
  logic        row_end;
  logic        last_write;
  logic [6:0]  nxt_cnt;
  logic [8:0]  nxt_line;
  logic [5:0]  nxt_col;
  logic [15:0] nxt_mask;

  assign row_end    = (blk_cnt_q == blk_last_q);
  assign last_write = row_end && (lines_left_q == 10'd1);
  assign nxt_cnt    = row_end ? 7'd0 : blk_cnt_q + 7'd1;
  assign nxt_line   = row_end ? line_q + 9'd1 : line_q;
  assign nxt_col    = blk_first_q + 6'(nxt_cnt);

  always_comb begin
    nxt_mask = 16'hFFFF;
    if (nxt_cnt == 7'd0) begin
      nxt_mask = (blk_last_q == 7'd0) ? (m_first_q & m_last_q) : m_first_q;
    end else if (nxt_cnt == blk_last_q) begin
      nxt_mask = m_last_q;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      line_q       <= '0;
      lines_left_q <= '0;
      blk_cnt_q    <= '0;
      blk_last_q   <= '0;
      blk_first_q  <= '0;
      m_first_q    <= '0;
      m_last_q     <= '0;
      adr_q        <= '0;
      mask_q       <= '0;
      value_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            line_q       <= y0;
            lines_left_q <= h;
            blk_cnt_q    <= '0;
            blk_first_q  <= x0[9:4];
            blk_last_q   <= start_last;
            m_first_q    <= start_mfirst;
            m_last_q     <= start_mlast;
            value_q      <= {16{fillBit}};
            adr_q        <= {y0, x0[9:4]};
            mask_q       <= start_mask;
            state_q      <= (w == 11'd0 || h == 10'd0) ? StDone : StFill;
          end
        end
        StFill: begin
          if (writeGrant) begin
            if (last_write) begin
              state_q <= StDone;
            end else begin
              blk_cnt_q <= nxt_cnt;
              line_q    <= nxt_line;
              if (row_end) lines_left_q <= lines_left_q - 10'd1;
              adr_q     <= {nxt_line, nxt_col};
              mask_q    <= nxt_mask;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy            = (state_q == StFill);
  assign stencilWriteSig = (state_q == StFill);
  assign fullMode        = (state_q == StFill);
  assign done            = (state_q == StDone);
  assign stencilWriteAdr = adr_q;
  assign writeMask16     = mask_q;
  assign writeValue16    = value_q;

endmodule

// File: tb/tb_stencil_fill_engine.sv
// Directed self-checking bench for stencil_fill_engine.
module tb_stencil_fill_engine;

  logic        clk = 1'b0;
  logic        nRST;
  logic        start;
  logic [9:0]  x0;
  logic [8:0]  y0;
  logic [10:0] w;
  logic [9:0]  h;
  logic        fillBit;
  logic        writeGrant;
  logic        busy, done, fullMode, stencilWriteSig;
  logic [14:0] stencilWriteAdr;
  logic [15:0] writeValue16, writeMask16;

  int checks = 0;
  int errors = 0;

  logic [31:0] gpat;
  int          done_at;
  logic [14:0] sa[$];
  logic [15:0] sm[$];
  logic [15:0] sv[$];
  logic        sg[$];

  stencil_fill_engine dut (
    .clk             (clk),
    .nRST            (nRST),
    .start           (start),
    .x0              (x0),
    .y0              (y0),
    .w               (w),
    .h               (h),
    .fillBit         (fillBit),
    .writeGrant      (writeGrant),
    .busy            (busy),
    .done            (done),
    .fullMode        (fullMode),
    .stencilWriteSig (stencilWriteSig),
    .stencilWriteAdr (stencilWriteAdr),
    .writeValue16    (writeValue16),
    .writeMask16     (writeMask16)
  );

  always #5 clk = ~clk;

  // Called #1 after a rising edge; returns in the done cycle (or after a cycle budget).
  task automatic go(input logic [9:0] ax, input logic [8:0] ay, input logic [10:0] aw,
                    input logic [9:0] ah, input logic fb);
    sa.delete(); sm.delete(); sv.delete(); sg.delete();
    done_at = -1;
    x0 = ax; y0 = ay; w = aw; h = ah; fillBit = fb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      writeGrant = (c <= 32) ? gpat[c-1] : 1'b1;
      if (done) begin
        done_at = c;
        break;
      end
      if (stencilWriteSig) begin
        sa.push_back(stencilWriteAdr);
        sm.push_back(writeMask16);
        sv.push_back(writeValue16);
        sg.push_back(writeGrant);
      end
      @(posedge clk); #1;
    end
    writeGrant = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0; fillBit = 1'b0;
    writeGrant = 1'b1; gpat = '1;
    #3;
    checks++;
    if ({busy, done, fullMode, stencilWriteSig, stencilWriteAdr, writeValue16, writeMask16} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b sig=%b adr=%h val=%h mask=%h want all 0",
               busy, done, stencilWriteSig, stencilWriteAdr, writeValue16, writeMask16);
    end
    @(posedge clk); @(posedge clk); #1;
    nRST = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stencilWriteSig !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b sig=%b want 0 0 0", busy, done, stencilWriteSig);
    end
  endtask

  task automatic test_basic();
    logic [14:0] ea [4];
    ea = '{15'h000, 15'h001, 15'h040, 15'h041};
    go(10'd0, 9'd0, 11'd32, 10'd2, 1'b1);
    checks++;
    if (done_at !== 5) begin errors++; $display("FAIL basic_done_at got %0d want 5", done_at); end
    checks++;
    if (sa.size() !== 4) begin errors++; $display("FAIL basic_nwrites got %0d want 4", sa.size()); end
    for (int i = 0; i < 4 && i < sa.size(); i++) begin
      checks++;
      if (sa[i] !== ea[i] || sm[i] !== 16'hFFFF || sv[i] !== 16'hFFFF) begin
        errors++;
        $display("FAIL basic_write%0d got adr=%h mask=%h val=%h want adr=%h mask=ffff val=ffff",
                 i, sa[i], sm[i], sv[i], ea[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_partial();
    go(10'd5, 9'd10, 11'd8, 10'd1, 1'b1);
    checks++;
    if (done_at !== 2) begin errors++; $display("FAIL partial_done_at got %0d want 2", done_at); end
    checks++;
    if (sa.size() !== 1 || sa[0] !== 15'h280 || sm[0] !== 16'h1FE0) begin
      errors++;
      $display("FAIL partial_write got n=%0d adr=%h mask=%h want n=1 adr=280 mask=1fe0",
               sa.size(), sa.size() > 0 ? sa[0] : 15'h0, sm.size() > 0 ? sm[0] : 16'h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [14:0] ea [4];
    logic [15:0] em [4];
    ea = '{15'h7FFF, 15'h7FC0, 15'h003F, 15'h0000};
    em = '{16'hF000, 16'h000F, 16'hF000, 16'h000F};
    go(10'd1020, 9'd511, 11'd8, 10'd2, 1'b0);
    checks++;
    if (done_at !== 5 || sa.size() !== 4) begin
      errors++;
      $display("FAIL wrap_count got done_at=%0d n=%0d want 5 4", done_at, sa.size());
    end
    for (int i = 0; i < 4 && i < sa.size(); i++) begin
      checks++;
      if (sa[i] !== ea[i] || sm[i] !== em[i] || sv[i] !== 16'h0000) begin
        errors++;
        $display("FAIL wrap_write%0d got adr=%h mask=%h val=%h want adr=%h mask=%h val=0000",
                 i, sa[i], sm[i], sv[i], ea[i], em[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_grant_stall();
    logic [14:0] ea [5];
    logic [15:0] em [5];
    int ng;
    ea = '{15'h0C0, 15'h0C1, 15'h0C1, 15'h0C1, 15'h0C2};
    em = '{16'hFFF0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0FFF};
    gpat = 32'hFFFF_FFF9;  // grants 1,0,0,1,1
    go(10'd4, 9'd3, 11'd40, 10'd1, 1'b1);
    gpat = '1;
    ng = 0;
    foreach (sg[i]) if (sg[i]) ng++;
    checks++;
    if (done_at !== 6 || sa.size() !== 5 || ng !== 3) begin
      errors++;
      $display("FAIL stall_count got done_at=%0d cycles=%0d grants=%0d want 6 5 3",
               done_at, sa.size(), ng);
    end
    for (int i = 0; i < 5 && i < sa.size(); i++) begin
      checks++;
      if (sa[i] !== ea[i] || sm[i] !== em[i]) begin
        errors++;
        $display("FAIL stall_cycle%0d got adr=%h mask=%h want adr=%h mask=%h",
                 i, sa[i], sm[i], ea[i], em[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    int nwr, dat;
    logic bad_adr;
    nwr = 0; dat = -1; bad_adr = 1'b0;
    x0 = 10'd0; y0 = 9'd0; w = 11'd64; h = 10'd1; fillBit = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 2) begin x0 = 10'd16; y0 = 9'd5; w = 11'd16; start = 1'b1; end
      if (c == 3) start = 1'b0;
      if (done) begin dat = c; break; end
      if (stencilWriteSig) begin
        if (stencilWriteAdr !== {9'd0, 6'(nwr)}) bad_adr = 1'b1;
        nwr++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dat !== 5 || nwr !== 4 || bad_adr) begin
      errors++;
      $display("FAIL midfill_start got done_at=%0d writes=%0d bad_adr=%b want 5 4 0", dat, nwr, bad_adr);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stencilWriteSig !== 1'b0) begin
      errors++;
      $display("FAIL done_start got busy=%b done=%b sig=%b want 0 0 0", busy, done, stencilWriteSig);
    end
    go(10'd7, 9'd2, 11'd0, 10'd3, 1'b1);
    checks++;
    if (done_at !== 1 || sa.size() !== 0) begin
      errors++;
      $display("FAIL w0_start got done_at=%0d writes=%0d want 1 0", done_at, sa.size());
    end
    @(posedge clk); #1;
    go(10'd7, 9'd2, 11'd20, 10'd0, 1'b1);
    checks++;
    if (done_at !== 1 || sa.size() !== 0) begin
      errors++;
      $display("FAIL h0_start got done_at=%0d writes=%0d want 1 0", done_at, sa.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midfill();
    logic saw_done;
    saw_done = 1'b0;
    x0 = 10'd0; y0 = 9'd0; w = 11'd64; h = 10'd1; fillBit = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (stencilWriteSig !== 1'b1 || stencilWriteAdr !== 15'h001) begin
      errors++;
      $display("FAIL rst_second_write got sig=%b adr=%h want 1 001", stencilWriteSig, stencilWriteAdr);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({busy, done, fullMode, stencilWriteSig, stencilWriteAdr, writeValue16, writeMask16} !== '0) begin
      errors++;
      $display("FAIL rst_midfill_outputs got busy=%b sig=%b adr=%h val=%h mask=%h want all 0",
               busy, stencilWriteSig, stencilWriteAdr, writeValue16, writeMask16);
    end
    @(posedge clk); #1;
    nRST = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL rst_no_done got activity=1 want 0"); end
    go(10'd0, 9'd0, 11'd32, 10'd2, 1'b1);
    checks++;
    if (done_at !== 5 || sa.size() !== 4 || sa[0] !== 15'h000 || sa[3] !== 15'h041) begin
      errors++;
      $display("FAIL rst_clean_fill got done_at=%0d n=%0d want 5 4 adr 000..041", done_at, sa.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_wrap();
    test_grant_stall();
    test_ignored_start();
    test_reset_midfill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stencil_fill_engine.md
# stencil_fill_engine

Rectangle fill/clear initiator for the GPU stencil cache. It walks a pixel rectangle as 16-pixel blocks, one row after another. For each block it issues one full-mode masked write on the stencil cache write port. Typical uses are clearing mask bits at frame start and preloading stencil state for a VRAM fill. It sits between the GPU command FSM, which issues start and geometry, and the stencil cache write port. An external arbiter grants that port against the rasterizer's pair-mode traffic.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock.
- nRST  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- x0  in  10  left pixel X (0..1023).
- y0  in  9  top line Y (0..511).
- w  in  11  width in pixels (0..1024).
- h  in  10  height in lines (0..512).
- fillBit  in  1  stencil value written to every covered pixel.
- writeGrant  in  1  arbiter grant; a write completes in a cycle where stencilWriteSig=1 and writeGrant=1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- fullMode  out  1  equals stencilWriteSig.
- stencilWriteSig  out  1  write request.
- stencilWriteAdr  out  15  block address {line[8:0], block[5:0]}; bit 6 is line[0] (bank select).
- writeValue16  out  16  {16{fillBit latched}}.
- writeMask16  out  16  per-pixel enable; bit i is pixel X = block*16+i (pair i>>1, select i&1).

## Operation
- States:
  - IDLE: busy=0, stencilWriteSig=0.
  - FILL: busy=1, stencilWriteSig=1.
  - DONE: busy=0, done=1, lasts one cycle, then IDLE.
- IDLE with start=1:
  - Latch x0, y0, fillBit.
  - Compute blkFirst=x0[9:4] and nBlk=((x0[3:0]+w-1)>>4)+1 (the sum is 12 bits).
  - Compute mFirst=16'hFFFF<<x0[3:0] and mLast=16'hFFFF>>(15-xe[3:0]), where xe=(x0+w-1) mod 1024.
  - Set the line counter to y0, the remaining-line count to h, and the block counter to 0.
  - If w=0 or h=0, go directly to DONE with no writes. Otherwise go to FILL.
- FILL, each granted write:
  - Advance the block column: (blkFirst+blkCnt) mod 64, so X wraps at 1024.
  - When blkCnt reaches nBlk-1, reset blkCnt to 0, increment the line mod 512 (Y wraps at 511→0), and decrement the remaining-line count.
  - The last granted write (last block, last line) moves the FSM to DONE.
- writeMask16 per block:
  - First block of a row: mFirst.
  - Last block of a row: mLast.
  - Block that is both first and last (nBlk=1): mFirst & mLast.
  - Any other block: 16'hFFFF.
- No grant: all write outputs hold their values and no counter advances.
- Start while busy or in DONE is ignored; it is neither queued nor latched.
- The block never reads the cache. Concurrent reads by others are legal only when their read address bit 6 differs from stencilWriteAdr[6].

## Timing
- Reset values: busy=0, done=0, fullMode=0, stencilWriteSig=0, stencilWriteAdr=0, writeValue16=0, writeMask16=0. The FSM goes to IDLE.
- Reset mid-fill: outputs clear immediately (asynchronous assert) and the fill is abandoned. No done pulse is generated.
- All outputs are registered or decoded from registered state only. There is no combinational path from the inputs, including writeGrant, to any output.
- start accepted at cycle T:
  - First write request is presented at T+1.
  - With constant grant there is one write per cycle, so the fill lasts nBlk*h cycles.
  - done is high the cycle after the last granted write; busy falls on that same cycle.
  - A new start is accepted no earlier than the cycle after done.
- w=0 or h=0: done at T+1, with zero write cycles.

## Test plan
- x0=0, y0=0, w=32, h=2, fillBit=1, grant tied high → 4 writes at adr 0x000, 0x001, 0x040, 0x041, each with mask FFFF and value FFFF; done at T+5.
- x0=5, y0=10, w=8, h=1 → one write at adr 0x280, mask 0x1FE0 (pixels 5..12); done at T+2.
- x0=1020, y0=511, w=8, h=2, fillBit=0:
  - Expected writes in order: 0x7FFF mask F000, 0x7FC0 mask 000F, 0x003F mask F000, 0x0000 mask 000F.
  - This checks X and Y wrap; value is 0000.
- Grant pattern 1,0,0,1,1 during a 3-block fill → address and mask are held stable while grant=0; exactly 3 writes occur; done follows the 3rd grant.
- start pulsed mid-fill, and w=0 start → the mid-fill start is ignored; the w=0 start gives a done pulse with no stencilWriteSig.
- nRST asserted during the 2nd write of a 4-write fill → outputs are 0 immediately, no done pulse, and the next start runs a clean fill.
